// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 stream multiplexer with fixed-select and round-robin modes.
// One output register stage; in_ready is combinational from the current grant.
module mux_nto1_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load_en;
  logic             w_fix_vld;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_ch_data [CHANNELS];

  assign w_load_en = !r_out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = w_load_en && w_grant_vld && (w_grant_idx == SEL_W'(gi));
    end
  endgenerate

  // An out-of-range select simply never grants; it must not alias onto a real channel.
  always_comb begin
    w_fix_vld = 1'b0;
    if (int'(sel) < CHANNELS) begin
      w_fix_vld = in_valid[sel];
    end
  end

  // Scan from farthest to nearest so the channel right after the pointer wins.
  always_comb begin
    int               v_cand;
    logic [SEL_W-1:0] v_idx;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      v_cand = int'(r_ptr) + k;
      if (v_cand >= CHANNELS) begin
        v_cand = v_cand - CHANNELS;
      end
      v_idx = SEL_W'(v_cand);
      if (in_valid[v_idx]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = v_idx;
      end
    end
  end

  assign w_grant_vld = mode ? w_rr_vld : w_fix_vld;
  assign w_grant_idx = mode ? w_rr_idx : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= SEL_W'(CHANNELS - 1);
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_out_data  <= w_ch_data[w_grant_idx];
        r_out_chan  <= w_grant_idx;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_grant_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Scoreboard bench for mux_nto1_reg: driver predicts accepted words from a
// simple arbitration model, a separate monitor checks them as they leave.
module tb_mux_nto1_reg;

  localparam int W  = 16;
  localparam int CH = 4;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [1:0]      sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_chan;

  // Three-channel instance for the out-of-range select case.
  logic [3*W-1:0]  d3_in_data;
  logic [2:0]      d3_in_valid;
  logic [2:0]      d3_in_ready;
  logic            d3_mode;
  logic [1:0]      d3_sel;
  logic [W-1:0]    d3_out_data;
  logic            d3_out_valid;
  logic            d3_out_ready;
  logic [1:0]      d3_out_chan;

  mux_nto1_reg #(.WIDTH(W), .CHANNELS(CH), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  mux_nto1_reg #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_chan(d3_out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  bit          m_valid;
  int          m_ptr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arbitration rule: fixed mode takes sel if in range and valid; RR takes the
  // first valid channel after the last RR winner, wrapping around.
  function automatic int model_grant();
    if (!mode) begin
      if (int'(sel) < CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= CH; k++) begin
      if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs set; checks, predicts, advances one cycle.
  task automatic step();
    int         g;
    bit         load;
    logic [3:0] er;
    #1;
    g    = model_grant();
    load = !m_valid || out_ready;
    er   = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (load) begin
      if (g >= 0) begin
        exp_q.push_back({2'(g), in_data[g*W +: W]});
        m_valid = 1'b1;
        if (mode) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr   = CH - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one pop per accepted output word.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn chan=%0d data=%04h exp_chan=%0d exp_data=%04h", out_chan, out_data, e[17:16], e[15:0]);
          chk("sb_chan", 32'(out_chan), 32'(e[17:16]));
          chk("sb_data", 32'(out_data), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    d3_in_data = '0; d3_in_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b0;
    m_valid = 1'b0; m_ptr = CH - 1;
    @(posedge clk);
    #1;
    do_reset();

    // Out-of-range select on a 3-channel instance.
    d3_in_data = {16'h00A2, 16'h00A1, 16'h00A0};
    d3_in_valid = 3'b111; d3_mode = 1'b1; d3_out_ready = 1'b0;
    #1 chk("d3_rr_ready", 32'(d3_in_ready), 32'b001);
    @(posedge clk); #1;
    chk("d3_loaded_chan", 32'(d3_out_chan), 32'd0);
    d3_mode = 1'b0; d3_sel = 2'd3; d3_out_ready = 1'b1;
    #1 chk("d3_oor_ready", 32'(d3_in_ready), 32'b000);
    chk("d3_valid_before", 32'(d3_out_valid), 32'd1);
    @(posedge clk); #1;
    chk("d3_valid_drop", 32'(d3_out_valid), 32'd0);
    chk("d3_data_kept", 32'(d3_out_data), 32'h00A0);
    d3_sel = 2'd2;
    #1 chk("d3_sel2_ready", 32'(d3_in_ready), 32'b100);
    @(posedge clk); #1;
    chk("d3_sel2_chan", 32'(d3_out_chan), 32'd2);
    chk("d3_sel2_data", 32'(d3_out_data), 32'h00A2);

    // Fixed-mode passthrough.
    in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    in_valid = 4'b0100; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    #1 chk("fixed_ready", 32'(in_ready), 32'b0100);
    step();
    chk("fixed_data", 32'(out_data), 32'hBEEF);
    chk("fixed_chan", 32'(out_chan), 32'd2);

    // RR fairness from reset.
    do_reset();
    in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    in_valid = 4'b1111; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq_chan", 32'(out_chan), 32'(i % 4));
    end

    // Backpressure.
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    step();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", 32'(out_data), 32'h1111);
    end
    out_ready = 1'b1; sel = 2'd3;
    step();
    step();

    // Sparse RR wrap from the reset pointer.
    do_reset();
    mode = 1'b1; in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-stream, then RR restarts at channel 0.
    in_valid = 4'b1111;
    step();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    do_reset();
    step();
    chk("post_reset_chan", 32'(out_chan), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_data   = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      step();
    end

    // Drain.
    in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
